gate_exhaustive_checker: RTL



---
 rtl/gate_exhaustive_checker.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/gate_exhaustive_checker.sv
// gate_exhaustive_checker
//
// Drives a 2-input gate under test through all four input combinations for
// N_PASSES sweeps. Each vector is held for SETTLE+1 cycles and the gate output
// is sampled on the last edge of that hold window. The sampled value is compared
// against the expected function selected by OP. Mismatches feed a saturating
// 8-bit error counter and a per-vector sticky failure map.
//
// Parameters
//   OP        expected function: 0=AND, 1=OR, 2=XOR, 3=NAND
//   N_PASSES  full 4-vector sweeps per run (1..255)
//   SETTLE    extra hold cycles per vector before sampling (0..15)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      run request, acted on only in IDLE or DONE
//   o          gate-under-test output (combinational from a/b)
//   a, b       registered gate inputs; vector k drives a=k[0], b=k[1]
//   busy       high while a run is in progress
//   done       high in DONE, held until the next start
//   pass       valid while done=1; high when no mismatch was seen
//   err_count  saturating mismatch count
//   fail_vec   bit k set if vector k mismatched at least once
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: start is a request sampled on every rising edge while the block
// is idle (IDLE or DONE); the accepting edge starts the run and clears the
// previous results. While busy=1 start is ignored. done=1 marks results valid
// and stays high until the next accepted start; holding start high from DONE
// therefore restarts on the edge after each run completes.

module gate_exhaustive_checker #(
  parameter int OP       = 0,
  parameter int N_PASSES = 1,
  parameter int SETTLE   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       o,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] fail_vec,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_SEL    = 2'(OP);
  localparam logic [7:0] LAST_PASS = 8'(N_PASSES - 1);
  localparam logic [3:0] SETTLE_L  = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic [3:0] settle_q, settle_d;
  logic       a_d, b_d;
  logic       pass_d;
  logic [7:0] err_d;
  logic [3:0] fail_vec_d;
  logic [7:0] err_inc;
  logic       mismatch;

  // Expected gate output for vector k (a=k[0], b=k[1]).
  function automatic logic gate_fn(input logic [1:0] k);
    logic r;
    case (OP_SEL)
      2'd0:    r = k[0] & k[1];
      2'd1:    r = k[0] | k[1];
      2'd2:    r = k[0] ^ k[1];
      default: r = ~(k[0] & k[1]);
    endcase
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    pass_cnt_d = pass_cnt_q;
    settle_d   = settle_q;
    a_d        = a;
    b_d        = b;
    err_d      = err_count;
    fail_vec_d = fail_vec;
    pass_d     = pass;
    mismatch   = 1'b0;
    err_inc    = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          k_d        = 2'd0;
          pass_cnt_d = 8'd0;
          settle_d   = 4'd0;
          a_d        = 1'b0;
          b_d        = 1'b0;
          err_d      = 8'd0;
          fail_vec_d = 4'd0;
          pass_d     = 1'b0;
        end
      end

      ST_RUN: begin
        if (settle_q == SETTLE_L) begin
          // Last edge of the hold window: sample o and move to the next vector.
          settle_d = 4'd0;
          mismatch = (o != gate_fn(k_q));
          if (mismatch) begin
            err_d      = err_inc;
            fail_vec_d = fail_vec | (4'b0001 << k_q);
          end
          k_d = k_q + 2'd1;
          a_d = k_d[0];
          b_d = k_d[1];
          if (k_q == 2'd3) begin
            if (pass_cnt_q == LAST_PASS) begin
              state_d = ST_DONE;
              a_d     = 1'b0;
              b_d     = 1'b0;
              // err_d already includes the final sample.
              pass_d  = (err_d == 8'd0);
            end else begin
              pass_cnt_d = pass_cnt_q + 8'd1;
            end
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= 2'd0;
      pass_cnt_q <= 8'd0;
      settle_q   <= 4'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      err_count  <= 8'd0;
      fail_vec   <= 4'd0;
      pass       <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      pass_cnt_q <= pass_cnt_d;
      settle_q   <= settle_d;
      a          <= a_d;
      b          <= b_d;
      err_count  <= err_d;
      fail_vec   <= fail_vec_d;
      pass       <= pass_d;
    end
  end

  // Decoded directly from the state register, so glitch-free.
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule
